// File: rtl/swcond_pkg.sv
// Shared types and constants for the switch conditioner.
package swcond_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } swcond_state_t;

  localparam int SW_WORD_W = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: non-blocking so the second stage takes the first stage's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/switch_conditioner.sv
// Synchronises and debounces the board switch vector as one unit, presenting a
// zero-extended stable word plus a one-cycle change pulse.
module switch_conditioner
  import swcond_pkg::*;
#(
  parameter int N_SW            = 17,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SW-1:0]      sw_raw,
  output logic [SW_WORD_W-1:0] sw_out,
  output logic                 sw_changed,
  output logic                 settling
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  swcond_state_t   r_state;
  swcond_state_t   w_next_state;
  logic [N_SW-1:0] w_sync;
  logic [N_SW-1:0] r_candidate;
  logic [N_SW-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic            r_sw_changed;
  logic            w_load_cand;
  logic            w_cnt_clr;
  logic            w_cnt_inc;
  logic            w_commit;

  sync_2ff #(
    .WIDTH(N_SW)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sw_raw),
    .q    (w_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_load_cand  = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync != r_stable) begin
          w_load_cand  = 1'b1;
          w_cnt_clr    = 1'b1;
          w_next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (w_sync == r_stable) begin
          w_cnt_clr    = 1'b1;
          w_next_state = IDLE;
        end else if (w_sync != r_candidate) begin
          w_load_cand = 1'b1;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt == CNT_MAX) begin
          w_commit     = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    settling = (r_state == SETTLE);
  end

  // The FSM leaves SETTLE at CNT_MAX, so the counter can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_candidate  <= '0;
      r_stable     <= '0;
      r_cnt        <= '0;
      r_sw_changed <= 1'b0;
    end else begin
      r_sw_changed <= w_commit;
      if (w_load_cand) r_candidate <= w_sync;
      if (w_commit)    r_stable    <= r_candidate;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign sw_out     = SW_WORD_W'(r_stable);
  assign sw_changed = r_sw_changed;

endmodule

// File: tb/tb_switch_conditioner.sv
// Randomised scoreboard bench for switch_conditioner; the reference model treats
// the input as a 2-cycle delay line and commits any value observed D+1 times in a row.
module tb_switch_conditioner;

  localparam int N_SW = 17;
  localparam int DC   = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [N_SW-1:0] sw_raw = '0;
  logic [31:0]     sw_out;
  logic            sw_changed;
  logic            settling;

  always #5 clk = ~clk;

  switch_conditioner #(
    .N_SW           (N_SW),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_out    (sw_out),
    .sw_changed(sw_changed),
    .settling  (settling)
  );

  typedef struct {
    logic [31:0] value;
    int          cyc;
  } commit_t;

  commit_t exp_q[$];
  int      vectors     = 0;
  int      miscompares = 0;
  int      cyc         = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: the value seen by the debouncer at an edge is the raw
  // input sampled two edges earlier; a value differing from the committed one
  // is committed once it has been seen on DC+1 consecutive edges.
  logic [N_SW-1:0] pipe[$];
  logic [N_SW-1:0] m_obs;
  logic [N_SW-1:0] m_stable   = '0;
  logic [N_SW-1:0] run_val    = '0;
  int              run_len    = 0;
  logic            m_settling = 1'b0;
  logic            m_pulse    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      m_stable   = '0;
      run_val    = '0;
      run_len    = 0;
      m_settling = 1'b0;
      m_pulse    = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      m_obs = pipe.pop_front();
      pipe.push_back(sw_raw);
      if (m_obs == run_val) run_len++;
      else begin
        run_val = m_obs;
        run_len = 1;
      end
      m_pulse = 1'b0;
      if (m_obs != m_stable && run_len >= DC + 1) begin
        m_stable = m_obs;
        m_pulse  = 1'b1;
        exp_q.push_back('{value: 32'(m_obs), cyc: cyc});
      end
      m_settling = (m_obs != m_stable);
    end
  end

  // Monitor: per-cycle level checks, plus a scoreboard pop on every pulse.
  always @(negedge clk) begin
    commit_t e;
    check("sw_out", sw_out, 32'(m_stable));
    check("settling", 32'(settling), 32'(m_settling));
    check("sw_changed", 32'(sw_changed), 32'(m_pulse));
    if (sw_changed === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse at cycle %0d: sw_out %h, no commit expected", cyc, sw_out);
      end else begin
        e = exp_q.pop_front();
        check("commit_value", sw_out, e.value);
        check("commit_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Driver runs at posedge+2, well away from both clock edges.
  task automatic step(input logic [N_SW-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sw_raw = v;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic async_reset(input int low_cycles);
    #1 rst_n = 1'b0;
    #1;
    check("rst_sw_out", sw_out, 32'h0);
    check("rst_settling", 32'(settling), 32'h0);
    check("rst_sw_changed", 32'(sw_changed), 32'h0);
    repeat (low_cycles) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [N_SW-1:0] pool[4];

  initial begin
    sw_raw = 17'h1FFFF;
    #1 rst_n = 1'b0;
    #1;
    check("por_sw_out", sw_out, 32'h0);
    check("por_settling", 32'(settling), 32'h0);
    check("por_sw_changed", 32'(sw_changed), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    step(17'h1FFFF, 12);
    step(17'h00000, 12);
    step(17'h0000A, 12);
    step(17'h00000, 12);
    step(17'h00005, 2);
    step(17'h00007, 12);
    step(17'h00003, 12);
    step(17'h00001, 2);
    step(17'h00003, 10);
    step(17'h00140, 12);
    step(17'h00032, 5);
    async_reset(3);
    step(17'h00032, 12);
    step(17'h10000, 1);
    step(17'h00032, 10);

    for (int i = 0; i < 4; i++) pool[i] = N_SW'($urandom);
    for (int s = 0; s < 300; s++) begin
      logic [N_SW-1:0] v;
      if ($urandom_range(0, 39) == 0) async_reset($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) v = N_SW'($urandom);
      else v = pool[$urandom_range(0, 3)];
      step(v, $urandom_range(1, 8));
    end
    step(sw_raw, 12);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Upstream input stage for the cpu SW port.
- Takes raw, asynchronous board switches and double-flop synchronises them.
- Debounces the whole switch vector as one unit and presents a stable, zero-extended 32-bit word to the core.
- Emits a one-cycle pulse whenever the committed value changes, so later IO logic can react without polling.

Parameters:
- N_SW, 17, number of physical switches (must be ≤ 32).
- DEBOUNCE_CYCLES, 500000, cycles the synchronised vector must hold unchanged before commit (10 ms at 50 MHz; must be ≥ 2).
- CNT_W, $clog2(DEBOUNCE_CYCLES), settle counter width (derived).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  N_SW  raw switch levels, asynchronous to clk.
- sw_out  output  32  debounced switches, bits [N_SW-1:0] valid, upper bits 0; drives cpu SW.
- sw_changed  output  1  one-cycle pulse on the cycle sw_out takes a new value.
- settling  output  1  high while a candidate value is being timed.

Behaviour:
- Reset (async, rst_n low):
  - Both sync stages, candidate, stable value, counter and sw_changed clear to 0.
  - FSM goes to IDLE.
  - sw_out = 0, settling = 0.
  - All of this holds immediately, independent of clk.
- Reset release: first capture occurs on the first rising clk edge after rst_n goes high.
- Synchroniser: sync1 <= sw_raw; sync2 <= sync1. Only sync2 is used downstream.
- FSM, two states, IDLE and SETTLE:
  - IDLE, sync2 == stable: hold.
  - IDLE, sync2 != stable: candidate <= sync2, cnt <= 0, go SETTLE.
  - SETTLE, sync2 == stable (bounce back to the old value): go IDLE, cnt <= 0, no pulse, sw_out unchanged.
  - SETTLE, sync2 != candidate and sync2 != stable (new bounce): candidate <= sync2, cnt <= 0, stay SETTLE.
  - SETTLE, sync2 == candidate and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - SETTLE, sync2 == candidate and cnt == DEBOUNCE_CYCLES-1: stable <= candidate, sw_changed <= 1, go IDLE.
- sw_changed is registered. It is high for exactly the one cycle following the commit edge, then 0.
- Latency: raw change set up before edge k, held constant thereafter:
  - sync2 updates at edge k+1.
  - SETTLE is entered at edge k+2.
  - Commit, i.e. the sw_out update, occurs at edge k+DEBOUNCE_CYCLES+2.
- settling = (state == SETTLE), a combinational decode of the state register.
- Width rules:
  - sw_out = {(32-N_SW)'b0, stable}.
  - The counter never wraps: it saturates by construction because the FSM leaves SETTLE at DEBOUNCE_CYCLES-1.
- Multiple bits changing at different times within the window: each change restarts the window. Only the final settled vector is committed, and it produces a single pulse.
- Reset asserted mid-SETTLE:
  - Candidate is discarded.
  - sw_out returns to 0.
  - No pulse is generated on reset exit.
- sw_out never shows an intermediate or metastable value. It changes only at commit edges or on reset.

Decomposition:
- Package swcond_pkg holds:
  - typedef enum logic {IDLE, SETTLE} swcond_state_t.
  - localparam SW_WORD_W = 32.
- Sub-module sync_2ff:
  - Parameter WIDTH.
  - Ports clk, rst_n, d, q.
  - Async clear to 0.
  - Instanced once with WIDTH = N_SW.
- FSM, counter and output registers stay in switch_conditioner.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, N_SW=17.
1. Reset hold and release: rst_n low with sw_raw=17'h1FFFF → sw_out=0, sw_changed=0, settling=0. After release with sw_raw held, sw_out=32'h0001FFFF at edge 6 and sw_changed high for 1 cycle.
2. Clean change: from stable 0, sw_raw=17'h0000A before edge k → settling high from k+2, sw_out=32'h0000000A at edge k+6, exactly one sw_changed pulse.
3. Bounce to new value: 0→5 held 2 cycles, then →7 held → window restarts, sw_out never shows 5, becomes 7 four cycles after the candidate reload, one pulse.
4. Bounce back to old value: stable 3, sw_raw →1 for 2 cycles then →3 → settling drops, sw_out stays 3, no pulse.
5. Reset mid-settle: stable 0x00140, change to 0x00032, assert rst_n at cnt=2 → sw_out=0 immediately (async). After release with 0x00032 held, commit at edge 6, one pulse.
6. Glitch shorter than the sync path: a 1-cycle sw_raw pulse of 17'h10000 → settling may assert, sw_out unchanged, no pulse.
